// File: rtl/mac_operand_feeder_if.sv
// Single operand stream channel: valid/ready handshake carrying data and byte strobes.
// Latency: none, wires only.
// Backpressure: the source holds valid and data stable until the sink raises ready.
interface mac_operand_feeder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/mac_operand_feeder.sv
// Splits one interleaved operand stream into c, a and b streams; MAC_FEEDER_STALL_CNT_EN adds a stall counter.
// Latency: an a/b pair is valid 1 cycle after its b word is accepted; c is valid 1 cycle after its word.
// Backpressure: output valids hold until handshake; in_i.ready drops while a pending pair is not consumed.
module mac_operand_feeder #(
  parameter  int unsigned CNT_LEN    = 1024,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned CW         = $clog2(CNT_LEN) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CW-1:0]         len_i,
  input  logic                  simple_mul_i,
  mac_operand_feeder_if.slave   in_i,
  mac_operand_feeder_if.master  a_o,
  mac_operand_feeder_if.master  b_o,
  mac_operand_feeder_if.master  c_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CW-1:0]         cnt_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_A, LOAD_B, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_c, r_stage;
  logic                  r_c_valid, pair_valid;
  logic [CW-1:0]         cnt_q, len_q;
  logic                  in_rdy, load_c, load_a, load_b;
  logic                  out_rdy, pair_hs, c_hs, job_start;

  // The engine takes a and b in one joint handshake, so both readys must be up.
  assign out_rdy   = a_o.ready & b_o.ready;
  assign pair_hs   = pair_valid & out_rdy;
  assign c_hs      = r_c_valid & c_o.ready;
  assign job_start = (state_q == IDLE) & start_i;

  // Next-state and input-ready decode. Ready is gated by enable_i so no word
  // is handshaken upstream on a cycle where the registers cannot capture it.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    load_c  = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!simple_mul_i)       state_d = LOAD_C;
          else if (len_i != '0)    state_d = LOAD_A;
          else                     state_d = DONE;
        end
      end
      LOAD_C: begin
        in_rdy = enable_i & ~r_c_valid;
        load_c = in_i.valid & in_rdy;
        if (load_c) state_d = (len_q != '0) ? LOAD_A : DRAIN;
      end
      LOAD_A: begin
        in_rdy = enable_i;
        load_a = in_i.valid & in_rdy;
        if (load_a) state_d = LOAD_B;
      end
      LOAD_B: begin
        in_rdy = enable_i & (~pair_valid | out_rdy);
        load_b = in_i.valid & in_rdy;
        if (load_b) state_d = ((cnt_q + 1'b1) == len_q) ? DRAIN : LOAD_A;
      end
      DRAIN: begin
        if (!pair_valid && !r_c_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, job parameters, operand registers and output valids.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_stage    <= '0;
      r_c_valid  <= 1'b0;
      pair_valid <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else if (enable_i) begin
      state_q <= state_d;
      if (job_start) begin
        cnt_q <= '0;
        len_q <= len_i;
      end
      if (load_c) begin
        r_c       <= in_i.data;
        r_c_valid <= 1'b1;
      end else if (c_hs) begin
        r_c_valid <= 1'b0;
      end
      if (load_a) r_stage <= in_i.data;
      // A reload in the same cycle as a pair handshake keeps valid high.
      if (load_b) begin
        r_a        <= r_stage;
        r_b        <= in_i.data;
        pair_valid <= 1'b1;
        if (cnt_q != len_q) cnt_q <= cnt_q + 1'b1;
      end else if (pair_hs) begin
        pair_valid <= 1'b0;
      end
    end
  end

  assign in_i.ready = in_rdy;
  assign a_o.valid  = pair_valid;
  assign b_o.valid  = pair_valid;
  assign c_o.valid  = r_c_valid;
  assign a_o.data   = r_a;
  assign b_o.data   = r_b;
  assign c_o.data   = r_c;
  assign a_o.strb   = '1;
  assign b_o.strb   = '1;
  assign c_o.strb   = '1;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign cnt_o      = cnt_q;

`ifdef MAC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_cond;

  assign stall_cond = (pair_valid & ~out_rdy) | (r_c_valid & ~c_o.ready);

  // Saturating count of cycles where a valid output waits on the engine.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      stall_q <= '0;
    end else if (enable_i) begin
      if (job_start)                         stall_q <= '0;
      else if (stall_cond && stall_q != '1)  stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: table of whole jobs plus hand-written corner sequences.
// Latency: inputs change 1ns after the rising edge; handshakes are recorded on the falling edge.
// Backpressure: sink readys are bench variables, the source holds each word until accepted.
`timescale 1ns/1ps
module tb_mac_operand_feeder;
  localparam int CW = 11;
`ifdef MAC_FEEDER_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          simple = 1'b0;
  logic [CW-1:0] len = '0;
  logic          busy, done;
  logic [CW-1:0] cnt;
  logic [31:0]   stall;
  logic          ab_rdy = 1'b1;
  logic          c_rdy = 1'b1;

  mac_operand_feeder_if #(.DATA_WIDTH(32)) in_if ();
  mac_operand_feeder_if #(.DATA_WIDTH(32)) a_if ();
  mac_operand_feeder_if #(.DATA_WIDTH(32)) b_if ();
  mac_operand_feeder_if #(.DATA_WIDTH(32)) c_if ();

  mac_operand_feeder #(.CNT_LEN(1024), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .start_i(start), .len_i(len), .simple_mul_i(simple),
    .in_i(in_if), .a_o(a_if), .b_o(b_if), .c_o(c_if),
    .busy_o(busy), .done_o(done), .cnt_o(cnt), .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  assign a_if.ready = ab_rdy;
  assign b_if.ready = ab_rdy;
  assign c_if.ready = c_rdy;
  assign in_if.strb = 4'h0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] src_q[$];
  logic [63:0] pair_q[$];
  logic [31:0] c_q[$];
  int          done_cnt = 0;
  int          pairs_at_done = 0;
  int          c_at_done = 0;

  // Handshake recorder: everything seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (in_if.valid && in_if.ready && src_q.size() > 0) src_q.delete(0);
    if (a_if.valid && a_if.ready && b_if.ready) pair_q.push_back({a_if.data, b_if.data});
    if (c_if.valid && c_if.ready) c_q.push_back(c_if.data);
    if (done) begin
      done_cnt++;
      pairs_at_done = pair_q.size();
      c_at_done = c_q.size();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (src_q.size() > 0) begin
      in_if.valid = 1'b1;
      in_if.data  = src_q[0];
    end else begin
      in_if.valid = 1'b0;
      in_if.data  = 32'h0;
    end
  endtask

  task automatic reset_bench();
    src_q.delete();
    pair_q.delete();
    c_q.delete();
    done_cnt = 0;
    step();
  endtask

  task automatic start_job(input logic sm, input logic [CW-1:0] l);
    simple = sm;
    len    = l;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int t;
    t = 0;
    while (done_cnt == 0 && t < limit) begin
      step();
      t++;
    end
    chk($sformatf("%s_done_seen", name), 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic chk_pair(input string name, input int idx, input logic [31:0] ea, input logic [31:0] eb);
    if (idx < pair_q.size()) chk($sformatf("%s_pair%0d", name, idx), pair_q[idx], {ea, eb});
    else                     chk($sformatf("%s_pair%0d_missing", name, idx), 64'(pair_q.size()), 64'(idx + 1));
  endtask

  typedef struct {
    logic          simple;
    logic [CW-1:0] len;
    int            nw;
    logic [31:0]   w [8];
    int            nc;
    logic [31:0]   c;
    int            np;
    logic [31:0]   pa [4];
    logic [31:0]   pb [4];
    int            left;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    string nm;
    int    t;

    vecs[0] = '{1'b1, 11'd3, 7, '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd0},
                0, 32'd0, 3, '{32'd1, 32'd3, 32'd5, 32'd0}, '{32'd2, 32'd4, 32'd6, 32'd0}, 1};
    vecs[1] = '{1'b0, 11'd2, 5, '{32'h10, 32'd7, 32'd8, 32'd9, 32'd10, 32'd0, 32'd0, 32'd0},
                1, 32'h10, 2, '{32'd7, 32'd9, 32'd0, 32'd0}, '{32'd8, 32'd10, 32'd0, 32'd0}, 0};
    vecs[2] = '{1'b1, 11'd0, 1, '{32'hAA, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                0, 32'd0, 0, '{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0}, 1};
    vecs[3] = '{1'b0, 11'd0, 2, '{32'h55, 32'h66, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                1, 32'h55, 0, '{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0}, 1};
    vecs[4] = '{1'b1, 11'd1, 3, '{32'hDEAD, 32'hBEEF, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                0, 32'd0, 1, '{32'hDEAD, 32'd0, 32'd0, 32'd0}, '{32'hBEEF, 32'd0, 32'd0, 32'd0}, 1};
    vecs[5] = '{1'b0, 11'd3, 7, '{32'hC0FFEE, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'd0},
                1, 32'hC0FFEE, 3, '{32'h11, 32'h33, 32'h55, 32'd0}, '{32'h22, 32'h44, 32'h66, 32'd0}, 0};

    in_if.valid = 1'b0;
    in_if.data  = 32'h0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pair_valid", 64'(a_if.valid | b_if.valid), 64'd0);
    chk("rst_c_valid", 64'(c_if.valid), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_in_ready", 64'(in_if.ready), 64'd0);
    rst_n = 1'b1;
    step();

    // Whole jobs with always-ready outputs
    for (int v = 0; v < NV; v++) begin
      nm = $sformatf("vec%0d", v);
      reset_bench();
      for (int i = 0; i < vecs[v].nw; i++) src_q.push_back(vecs[v].w[i]);
      start_job(vecs[v].simple, vecs[v].len);
      wait_done(nm, 100);
      repeat (3) step();
      chk({nm, "_done_once"}, 64'(done_cnt), 64'd1);
      chk({nm, "_busy_after"}, 64'(busy), 64'd0);
      chk({nm, "_cnt"}, 64'(cnt), 64'(vecs[v].len));
      chk({nm, "_c_count"}, 64'(c_q.size()), 64'(vecs[v].nc));
      if (vecs[v].nc > 0 && c_q.size() > 0) chk({nm, "_c_data"}, 64'(c_q[0]), 64'(vecs[v].c));
      chk({nm, "_pair_count"}, 64'(pair_q.size()), 64'(vecs[v].np));
      for (int i = 0; i < vecs[v].np; i++) chk_pair(nm, i, vecs[v].pa[i], vecs[v].pb[i]);
      chk({nm, "_pairs_before_done"}, 64'(pairs_at_done), 64'(vecs[v].np));
      chk({nm, "_c_before_done"}, 64'(c_at_done), 64'(vecs[v].nc));
      chk({nm, "_left_upstream"}, 64'(src_q.size()), 64'(vecs[v].left));
    end

    // Zero-length simple job: done exactly one cycle after start, nothing consumed
    reset_bench();
    src_q.push_back(32'hAA);
    start_job(1'b1, 11'd0);
    chk("len0_done_next_cycle", 64'(done), 64'd1);
    chk("len0_busy_in_done", 64'(busy), 64'd1);
    step();
    chk("len0_done_single", 64'(done), 64'd0);
    chk("len0_idle", 64'(busy), 64'd0);
    chk("len0_nothing_taken", 64'(src_q.size()), 64'd1);

    // Back-pressure: first pair held for 5 cycles
    reset_bench();
    foreach (vecs[1].w[i]) if (i < vecs[1].nw) src_q.push_back(vecs[1].w[i]);
    ab_rdy = 1'b0;
    start_job(1'b0, 11'd2);
    t = 0;
    while (!a_if.valid && t < 50) begin
      step();
      t++;
    end
    chk("bp_pair_seen", 64'(a_if.valid), 64'd1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_hold%0d", j), {a_if.data, b_if.data}, {32'd7, 32'd8});
      chk($sformatf("bp_valid%0d", j), 64'({a_if.valid, b_if.valid}), 64'd3);
      if (j > 0) chk($sformatf("bp_in_ready%0d", j), 64'(in_if.ready), 64'd0);
      step();
    end
    chk("bp_word_pending", 64'(src_q.size()), 64'd1);
    chk("bp_stall_cnt", 64'(stall), 64'(EXP_STALL));
    ab_rdy = 1'b1;
    wait_done("bp", 100);
    repeat (2) step();
    chk("bp_done_once", 64'(done_cnt), 64'd1);
    chk("bp_c_count", 64'(c_q.size()), 64'd1);
    chk("bp_pair_count", 64'(pair_q.size()), 64'd2);
    chk_pair("bp", 0, 32'd7, 32'd8);
    chk_pair("bp", 1, 32'd9, 32'd10);
    chk("bp_stall_final", 64'(stall), 64'(EXP_STALL));

    // Clear mid-job after first of four pairs, then a normal job
    reset_bench();
    for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
    start_job(1'b1, 11'd4);
    t = 0;
    while (pair_q.size() < 1 && t < 50) begin
      step();
      t++;
    end
    chk("clr_first_pair", 64'(pair_q.size()), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_valids", 64'({a_if.valid, b_if.valid, c_if.valid}), 64'd0);
    chk("clr_cnt", 64'(cnt), 64'd0);
    chk("clr_stall", 64'(stall), 64'd0);
    repeat (3) step();
    chk("clr_no_done", 64'(done_cnt), 64'd0);
    reset_bench();
    for (int i = 11; i <= 14; i++) src_q.push_back(32'(i));
    start_job(1'b1, 11'd2);
    wait_done("clr_next", 100);
    repeat (2) step();
    chk("clr_next_pairs", 64'(pair_q.size()), 64'd2);
    chk_pair("clr_next", 0, 32'd11, 32'd12);
    chk_pair("clr_next", 1, 32'd13, 32'd14);
    chk("clr_next_cnt", 64'(cnt), 64'd2);

    // Start while busy is ignored; enable low freezes the block
    reset_bench();
    for (int i = 1; i <= 6; i++) src_q.push_back(32'(i));
    start_job(1'b1, 11'd2);
    start = 1'b1;
    len   = 11'd5;
    step();
    start = 1'b0;
    len   = '0;
    step();
    chk("en_cnt_before", 64'(cnt), 64'd1);
    ab_rdy = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en_cnt_frozen%0d", k), 64'(cnt), 64'd1);
      chk($sformatf("en_valid_frozen%0d", k), 64'({a_if.valid, b_if.valid, c_if.valid}), 64'd6);
    end
    enable = 1'b1;
    ab_rdy = 1'b1;
    wait_done("en", 100);
    repeat (2) step();
    chk("en_done_once", 64'(done_cnt), 64'd1);
    chk("en_pairs", 64'(pair_q.size()), 64'd2);
    chk_pair("en", 0, 32'd1, 32'd2);
    chk_pair("en", 1, 32'd3, 32'd4);
    chk("en_cnt_final", 64'(cnt), 64'd2);
    chk("en_left_upstream", 64'(src_q.size()), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Transmitter side of the MAC engine's operand interface. Takes one 32b HWPE-Stream of interleaved operands from a single streamer and splits it into the engine's c, a and b sink streams.
- Stream order:
  - scalar-product mode: c, then a0, b0, a1, b1, …
  - simple-multiply mode: a0, b0, a1, b1, …
- Emits each a/b pair as one simultaneous valid on both outputs, which is what the engine's joint a/b handshake requires.
- Sits between the operand source streamer and the MAC engine in the accelerator datapath.

Parameters:
- CNT_LEN, 1024, maximum number of a/b pairs per job; counter width is $clog2(CNT_LEN)+1.
- DATA_WIDTH, 32, width of every stream's data field.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; synchronous, active-low
- enable_i  input  1  global enable; when low, all registers hold
- clear_i  input  1  synchronous soft clear; same effect as reset
- start_i  input  1  one-cycle job start pulse
- len_i  input  $clog2(CNT_LEN)+1  number of a/b pairs for this job
- simple_mul_i  input  1  1 = no c word; 0 = first input word is c
- in_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  interleaved operand stream
- a_o  hwpe_stream_intf_stream.source  DATA_WIDTH  a operand stream
- b_o  hwpe_stream_intf_stream.source  DATA_WIDTH  b operand stream
- c_o  hwpe_stream_intf_stream.source  DATA_WIDTH  c (accumulator init) stream
- busy_o  output  1  job in progress (FSM not in IDLE)
- done_o  output  1  one-cycle pulse at job end
- cnt_o  output  $clog2(CNT_LEN)+1  pairs emitted in the current job
- stall_cnt_o  output  32  back-pressure cycle counter (optional feature)

Behaviour:
- Reset or clear_i:
  - FSM goes to IDLE.
  - r_c_valid=0, pair_valid=0, cnt=0.
  - done_o=0, busy_o=0, stall_cnt=0.
  - Data registers are cleared to 0.
  - Reset or clear mid-job aborts the job immediately; no done pulse, all output valids drop on the next cycle.
- All state updates require enable_i=1. clear_i has priority over enable_i.
- Outputs:
  - a_o.valid = b_o.valid = pair_valid; c_o.valid = r_c_valid.
  - All three strb = '1. in_i.strb is ignored.
  - Output data is registered; a_o.data = r_a, b_o.data = r_b, c_o.data = r_c.
- Pair handshake: pair_valid & a_o.ready & b_o.ready. On handshake pair_valid clears unless it is reloaded in the same cycle.
- c handshake: r_c_valid & c_o.ready clears r_c_valid.
- FSM states and in_i.ready:
  - IDLE: in_i.ready=0.
    - On start_i with simple_mul_i=0: go to LOAD_C.
    - On start_i with simple_mul_i=1 and len_i>0: go to LOAD_A.
    - On start_i with simple_mul_i=1 and len_i=0: go to DONE.
    - cnt←0 on start. len_i and simple_mul_i are latched at start.
  - LOAD_C: in_i.ready = ~r_c_valid.
    - On handshake: r_c←data, r_c_valid←1.
    - Next state is LOAD_A if len>0, else DRAIN.
  - LOAD_A: in_i.ready=1. On handshake: r_stage←data, go to LOAD_B.
  - LOAD_B: in_i.ready = ~pair_valid | (a_o.ready & b_o.ready).
    - On handshake: r_a←r_stage, r_b←data, pair_valid←1, cnt←cnt+1.
    - Next state is DRAIN if cnt+1==len, else LOAD_A.
  - DRAIN: in_i.ready=0. Go to DONE when pair_valid=0 and r_c_valid=0.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- start_i outside IDLE is ignored.
- in_i is never accepted outside LOAD_C/LOAD_A/LOAD_B; extra input words stay pending upstream.
- Valid never deasserts without a handshake.
- Data on a, b and c is stable while valid & ~ready.
- Latency: a pair becomes valid 1 cycle after the b word handshake. Sustained throughput is 1 pair per 2 input cycles.
- c and the first pair may be valid simultaneously; each handshakes independently.
- cnt_o saturates at len; it is never allowed to wrap.

Optional Feature:
- MAC_FEEDER_STALL_CNT_EN defined:
  - stall_cnt_o is a 32b counter.
  - Increments each enabled cycle with (pair_valid & ~(a_o.ready & b_o.ready)) | (r_c_valid & ~c_o.ready).
  - Saturates at 0xFFFFFFFF.
  - Cleared on start_i accepted in IDLE, on clear_i, and on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
- simple_mul_i=1, len_i=3, input 1,2,3,4,5,6, outputs always ready → pairs (1,2), (3,4), (5,6); c_o.valid never asserted; cnt_o=3; exactly one done_o pulse; busy_o drops after it.
- simple_mul_i=0, len_i=2, input 0x10,7,8,9,10 → c_o delivers 0x10 once, then pairs (7,8), (9,10); done_o pulses only after all three handshakes.
- Same as previous, but a_o/b_o ready held low 5 cycles after the first pair → pair (7,8) held stable; in_i.ready=0 in LOAD_B; stall_cnt_o=5 with macro, 0 without.
- simple_mul_i=1, len_i=0 → IDLE→DONE→IDLE; done_o pulses 1 cycle after start; no input word consumed. simple_mul_i=0, len_i=0 → only c is consumed and emitted, then done_o.
- clear_i asserted mid-job after 1 of 4 pairs → next cycle busy_o=0, all valids 0, cnt_o=0, no done_o. A following start with len_i=2 completes normally.
- start_i pulsed while busy with len_i=5 → ignored; the original job's len of 2 is honoured; enable_i low for 3 cycles freezes cnt_o and all valids.
